// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin front end that shares one cache read port
// between NUM_REQ requesters. It accepts one request at a time, issues a
// single-cycle cache_read with a stable address, waits RESP_LAT cycles,
// captures data and hit flags, and returns them with a one-cycle strobe.
//
// Handshake: a request is accepted on a rising edge where
// req_valid[i] && req_ready[i]. req_ready is combinational, one-hot and only
// raised in IDLE. resp_valid[i] is a one-cycle strobe with no back-pressure.
//
// Optional build macro CACHE_ARB_STATS_EN adds stat_clear and saturating
// hit/miss counters (stat_l1_hits, stat_l2_hits, stat_misses).
module cache_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int RESP_LAT   = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          resp_l1_hit,
   output logic                          resp_l2_hit,
   output logic                          busy,
   output logic                          cache_read,
   output logic [ADDR_WIDTH-1:0]         cache_addr,
   input  logic [DATA_WIDTH-1:0]         cache_read_data,
   input  logic                          cache_l1_hit,
   input  logic                          cache_l2_hit
`ifdef CACHE_ARB_STATS_EN
   ,
   input  logic                          stat_clear,
   output logic [CNT_WIDTH-1:0]          stat_l1_hits,
   output logic [CNT_WIDTH-1:0]          stat_l2_hits,
   output logic [CNT_WIDTH-1:0]          stat_misses
`endif
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

   // Reject unsupported configurations at elaboration time.
   if (NUM_REQ < 2 || NUM_REQ > 8 || RESP_LAT < 1 || CNT_WIDTH < 1) begin : g_bad_param
      $error("cache_req_arbiter: unsupported parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] id_q;
   logic [IDW-1:0] grant_id;
   logic           grant_found;
   logic [CW-1:0]  wait_cnt;
   logic           capture;

   // Capture edge: last WAIT cycle, cache outputs are sampled at its close.
   assign capture = (state == WAIT) && (wait_cnt == '0);

   // Round-robin search: first valid requester at or above ptr, wrapping.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = IDW'(idx);
         end
      end
   end

   // One-hot grant, only while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && grant_found && !rst) req_ready[grant_id] = 1'b1;
   end

   // Main FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         id_q        <= '0;
         wait_cnt    <= '0;
         cache_read  <= 1'b0;
         cache_addr  <= '0;
         busy        <= 1'b0;
         resp_valid  <= '0;
         resp_data   <= '0;
         resp_l1_hit <= 1'b0;
         resp_l2_hit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  id_q       <= grant_id;
                  cache_addr <= req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                  ptr        <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
                  cache_read <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               cache_read <= 1'b0;
               wait_cnt   <= CW'(RESP_LAT-1);
               state      <= WAIT;
            end
            WAIT: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - CW'(1);
               end else begin
                  resp_data   <= cache_read_data;
                  // Both flags set is reported as an L1 hit only.
                  resp_l1_hit <= cache_l1_hit;
                  resp_l2_hit <= cache_l2_hit & ~cache_l1_hit;
                  resp_valid  <= NUM_REQ'(1) << id_q;
                  state       <= RESP;
               end
            end
            RESP: begin
               resp_valid <= '0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_ARB_STATS_EN
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Saturating hit/miss counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_l1_hits <= '0;
         stat_l2_hits <= '0;
         stat_misses  <= '0;
      end else if (stat_clear) begin
         stat_l1_hits <= '0;
         stat_l2_hits <= '0;
         stat_misses  <= '0;
      end else if (capture) begin
         if (cache_l1_hit) begin
            if (stat_l1_hits != CNT_MAX) stat_l1_hits <= stat_l1_hits + CNT_WIDTH'(1);
         end else if (cache_l2_hit) begin
            if (stat_l2_hits != CNT_MAX) stat_l2_hits <= stat_l2_hits + CNT_WIDTH'(1);
         end else begin
            if (stat_misses != CNT_MAX) stat_misses <= stat_misses + CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Round-robin front end that shares one cache_system_4way read port between NUM_REQ requesters.
- Accepts one request at a time and drives a single-cycle read pulse plus a stable address into the cache.
- Waits a fixed RESP_LAT cycles, captures read data and the L1/L2 hit flags, then returns them to the originating requester with a one-cycle valid strobe.
- Sits between the core-side request ports and the two-level cache system.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- ADDR_WIDTH, 11: address width; matches the cache.
- DATA_WIDTH, 32: read data width.
- RESP_LAT, 2: cycles from the cache_read cycle to the cycle whose closing edge samples the cache outputs; must be >= 1.
- CNT_WIDTH, 16: statistics counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted on an edge where req_valid[i] && req_ready[i].
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- resp_data  out  DATA_WIDTH  response data; shared by all requesters.
- resp_l1_hit  out  1  response L1 hit flag.
- resp_l2_hit  out  1  response L2 hit flag.
- busy  out  1  high in any state other than IDLE.
- cache_read  out  1  read pulse to the cache.
- cache_addr  out  ADDR_WIDTH  address to the cache.
- cache_read_data  in  DATA_WIDTH  cache read data.
- cache_l1_hit  in  1  cache L1 hit.
- cache_l2_hit  in  1  cache L2 hit.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, latched address/id 0.
- A reset asserted mid-operation abandons the in-flight request; no resp_valid is produced for it.
- State IDLE:
  - req_ready is combinational: at most one bit is set, only in IDLE.
  - The grant goes to the first requester with req_valid set, searching from the pointer upward with wrap-around.
  - On acceptance: latch the address and requester id, set pointer = id+1 (wrapping from NUM_REQ-1 to 0), go to ISSUE.
  - No req_valid set: remain in IDLE.
- State ISSUE:
  - cache_read=1 for exactly this cycle; cache_addr = latched address.
  - Load the wait counter with RESP_LAT-1, go to WAIT.
- State WAIT:
  - cache_read=0; cache_addr holds the latched address.
  - Counter > 0: decrement.
  - Counter == 0: at this edge register cache_read_data into resp_data and the hit flags into resp_l1_hit/resp_l2_hit, then go to RESP.
  - If both cache hit flags are set, report L1 hit only.
- State RESP:
  - resp_valid[id]=1 for this cycle only.
  - resp_data and the hit flags hold their values until the next capture.
  - Go to IDLE.
  - A new grant is possible in the following cycle.
- Latency: acceptance edge T → cache_read high in cycle T+1 → resp_valid high in cycle T+RESP_LAT+2.
- Throughput: one request per RESP_LAT+3 cycles.
- Requester rules:
  - A requester keeps req_valid high and req_addr stable until granted.
  - Dropping req_valid before a grant is legal and leaves no side effect.
  - Changes to req_valid or req_addr after acceptance do not affect the in-flight request.
- Miss classification: neither hit flag set; resp_data still returns the cache value.

Optional Feature:
- Macro CACHE_ARB_STATS_EN.
- When defined:
  - Adds input stat_clear (1) and outputs stat_l1_hits, stat_l2_hits, stat_misses (CNT_WIDTH each).
  - Exactly one counter increments at the WAIT capture edge, using the same classification as resp_l1_hit/resp_l2_hit.
  - Counters saturate at all-ones.
  - stat_clear zeroes all counters synchronously and takes priority over a same-cycle increment.
  - rst zeroes all counters.
- When undefined: these ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
- Single request: requester 0 sends addr 0x020 with RESP_LAT=2, cache model returns 0xDEADBEEF with l1_hit=0 and l2_hit=0 → req_ready[0] high in the accept cycle; cache_read high one cycle later with cache_addr=0x020; resp_valid=4'b0001 three cycles after that with resp_data=0xDEADBEEF and both hit flags 0.
- Contention: all four requesters assert req_valid from reset (addrs 0x020, 0x040, 0x060, 0x080) → grant order 0,1,2,3; each response goes to the matching requester with the matching data; busy stays high between grants apart from the one IDLE cycle.
- Fairness: requesters 1 and 3 hold req_valid continuously for 6 grants → grants alternate 1,3,1,3,1,3.
- Hit flags: model returns l1_hit=1 on the second access to 0x020 and l2_hit=1 on 0x040 → resp_l1_hit=1 and resp_l2_hit=1 on the respective responses; with both flags forced to 1, the response shows l1_hit=1 and l2_hit=0.
- Reset mid-WAIT: assert rst one cycle after cache_read → all outputs 0 immediately; no resp_valid is seen; the next request from requester 2 gets resp_valid=4'b0100 at the normal latency.
- Stats (CACHE_ARB_STATS_EN): run 10 accesses yielding 3 L1 hits, 2 L2 hits and 5 misses → counters read 3/2/5; stat_clear pulsed during a capture edge → all counters 0.
